// File: rtl/multi_blink.sv
// Multi-channel LED blinker: shared tick prescaler, per-channel mode/half-period set over a valid/ready port.
// Config and sync take effect on led_o the cycle after acceptance; cfg_ready_o stays high once out of reset.
module multi_blink #(
  parameter int FREQ     = 0,
  parameter int SECS     = 0,
  parameter int CHANNELS = 4,
  parameter int TICK_HZ  = 1000,
  parameter int HW       = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sync_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [4:0]          cfg_chan_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [HW-1:0]       cfg_half_i,
  output logic                cfg_err_o,
  output logic [CHANNELS-1:0] led_o
);

  localparam int DIV      = (TICK_HZ > 0) ? FREQ / TICK_HZ : 0;
  localparam int PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam longint HALF_FULL = (longint'(SECS) * longint'(TICK_HZ)) / 2;
  localparam logic [PW-1:0] DIV_M1   = PW'((DIV > 0) ? DIV - 1 : 0);
  localparam logic [HW-1:0] HALF_RST = (HALF_FULL == 0) ? HW'(1) : HW'(HALF_FULL);

  if (FREQ <= 0) begin : g_bad_freq
    $error("multi_blink: FREQ must be nonzero");
  end
  if (SECS <= 0) begin : g_bad_secs
    $error("multi_blink: SECS must be nonzero");
  end
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_chan
    $error("multi_blink: CHANNELS must be 1..32");
  end
  if (DIV < 1) begin : g_bad_div
    $error("multi_blink: FREQ/TICK_HZ must be at least 1");
  end
  if (HALF_FULL >= (longint'(1) << HW)) begin : g_bad_hw
    $error("multi_blink: reset half-period does not fit in HW bits");
  end

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_ON      = 2'd1,
    M_BLINK   = 2'd2,
    M_ONESHOT = 2'd3
  } mode_e;

  logic [PW-1:0]               pre_q, pre_d;
  logic                        ready_q, ready_d;
  logic                        err_q, err_d;
  logic [CHANNELS-1:0]         led_q, led_d;
  logic [CHANNELS-1:0][HW-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][HW-1:0] half_q, half_d;
  mode_e                       mode_q [CHANNELS];
  mode_e                       mode_d [CHANNELS];

  logic tick;
  logic accept;
  logic chan_ok;

  always_comb begin
    tick    = (pre_q == DIV_M1);
    accept  = cfg_valid_i && ready_q;
    chan_ok = ({1'b0, cfg_chan_i} < 6'(CHANNELS));
    pre_d   = (sync_i || tick) ? '0 : pre_q + PW'(1);
    ready_d = 1'b1;
    err_d   = accept && !chan_ok;

    for (int c = 0; c < CHANNELS; c++) begin
      mode_d[c] = mode_q[c];
      half_d[c] = half_q[c];
      cnt_d[c]  = cnt_q[c];
      led_d[c]  = led_q[c];

      // A write outranks both sync and a coincident toggle tick.
      if (accept && chan_ok && (cfg_chan_i == 5'(c))) begin
        mode_d[c] = mode_e'(cfg_mode_i);
        half_d[c] = (cfg_half_i == '0) ? HW'(1) : cfg_half_i;
        cnt_d[c]  = '0;
        led_d[c]  = (cfg_mode_i == M_ON) || (cfg_mode_i == M_ONESHOT);
      end else if (sync_i) begin
        cnt_d[c] = '0;
        if (mode_q[c] == M_BLINK) begin
          led_d[c] = 1'b0;
        end else if (mode_q[c] == M_ONESHOT) begin
          led_d[c] = 1'b1;
        end
      end else if (tick && ((mode_q[c] == M_BLINK) || (mode_q[c] == M_ONESHOT))) begin
        if (cnt_q[c] == half_q[c] - HW'(1)) begin
          cnt_d[c] = '0;
          if (mode_q[c] == M_BLINK) begin
            led_d[c] = ~led_q[c];
          end else begin
            led_d[c]  = 1'b0;
            mode_d[c] = M_OFF;
          end
        end else begin
          cnt_d[c] = cnt_q[c] + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= '0;
      cnt_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        half_q[c] <= HALF_RST;
        mode_q[c] <= M_BLINK;
      end
    end else begin
      pre_q   <= pre_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c] <= mode_d[c];
      end
    end
  end

  assign cfg_ready_o = ready_q;
  assign cfg_err_o   = err_q;
  assign led_o       = led_q;

endmodule

// File: tb/tb_multi_blink.sv
// Directed bench for multi_blink: DIV=10, reset half=5, four channels.
// Cycle n is the n-th clock after reset release; outputs are sampled on the falling edge.
module tb_multi_blink;

  localparam int CH = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          sync_i = 1'b0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [4:0]    cfg_chan_i = '0;
  logic [1:0]    cfg_mode_i = '0;
  logic [15:0]   cfg_half_i = '0;
  logic          cfg_err_o;
  logic [CH-1:0] led_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  multi_blink #(
    .FREQ(100), .SECS(1), .CHANNELS(CH), .TICK_HZ(10), .HW(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sync_i(sync_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_chan_i(cfg_chan_i), .cfg_mode_i(cfg_mode_i), .cfg_half_i(cfg_half_i),
    .cfg_err_o(cfg_err_o), .led_o(led_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic go(input int n);
    while (cyc < n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni      = 1'b0;
    sync_i      = 1'b0;
    cfg_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic write(input logic [4:0] ch, input logic [1:0] mode,
                       input logic [15:0] half, input logic sync);
    cfg_valid_i = 1'b1;
    cfg_chan_i  = ch;
    cfg_mode_i  = mode;
    cfg_half_i  = half;
    sync_i      = sync;
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    sync_i      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Idle blinking from reset
    do_reset();
    chk("rst_ready", cfg_ready_o, 0);
    chk("rst_led",   led_o, 4'h0);
    chk("rst_err",   cfg_err_o, 0);
    go(1);   chk("ready_up",  cfg_ready_o, 1);
    go(49);  chk("idle_c49",  led_o, 4'h0);
    go(50);  chk("idle_c50",  led_o, 4'hF);
    go(99);  chk("idle_c99",  led_o, 4'hF);
    go(100); chk("idle_c100", led_o, 4'h0);
    go(149); chk("idle_c149", led_o, 4'h0);
    go(150); chk("idle_c150", led_o, 4'hF);

    // ON / OFF writes, then sync leaves ON alone
    do_reset();
    go(20);
    write(5'd1, 2'd1, 16'd5, 1'b0);
    chk("on_c21", led_o, 4'b0010);
    write(5'd2, 2'd0, 16'd5, 1'b0);
    chk("off_c22", led_o, 4'b0010);
    go(49);  chk("onoff_c49", led_o, 4'b0010);
    go(50);  chk("onoff_c50", led_o, 4'b1011);
    go(60);  chk("onoff_c60", led_o, 4'b1011);
    sync_i = 1'b1;
    @(negedge clk_i);
    sync_i = 1'b0;
    chk("sync_keeps_on", led_o, 4'b0010);

    // ONESHOT half=3 written on a tick cycle
    do_reset();
    go(29);
    write(5'd0, 2'd3, 16'd3, 1'b0);
    chk("os_c30",  led_o, 4'b0001);
    go(49);  chk("os_c49",  led_o, 4'b0001);
    go(59);  chk("os_c59",  led_o, 4'b1111);
    go(60);  chk("os_c60",  led_o, 4'b1110);
    go(100); chk("os_c100", led_o, 4'b0000);
    go(150); chk("os_c150", led_o, 4'b1110);

    // Out-of-range channel
    go(151);
    chk("err_idle", cfg_err_o, 0);
    write(5'd7, 2'd1, 16'd5, 1'b0);
    chk("err_pulse", cfg_err_o, 1);
    chk("err_led",   led_o, 4'b1110);
    @(negedge clk_i);
    chk("err_clear", cfg_err_o, 0);
    go(200); chk("err_c200", led_o, 4'b0000);

    // Write plus sync in the same cycle
    do_reset();
    go(73);  chk("ws_c73",  led_o, 4'hF);
    write(5'd3, 2'd2, 16'd2, 1'b1);
    chk("ws_c74", led_o, 4'h0);
    go(93);  chk("ws_c93",  led_o, 4'b0000);
    go(94);  chk("ws_c94",  led_o, 4'b1000);
    go(113); chk("ws_c113", led_o, 4'b1000);
    go(114); chk("ws_c114", led_o, 4'b0000);
    go(123); chk("ws_c123", led_o, 4'b0000);
    go(124); chk("ws_c124", led_o, 4'b0111);

    // Reset mid-operation
    do_reset();
    go(57);  chk("mr_c57", led_o, 4'hF);
    rst_ni = 1'b0;
    #1;
    chk("mr_led_now",   led_o, 4'h0);
    chk("mr_ready_now", cfg_ready_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    go(49);  chk("mr_c49", led_o, 4'h0);
    go(50);  chk("mr_c50", led_o, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
